io_cell_cfg_ctrl: RTL
=====================

IO_CELL_CFG_CTRL -- requirements
Module: io_cell_cfg_ctrl

Interface
REQ-001 SHALL have parameter NUM_CELLS, default 25, number of IO cells served (1..64).
REQ-002 SHALL have parameter CONF_WIDTH, default 5, config bits per cell (1..32).
REQ-003 SHALL have parameter FILT_LEN, default 4, glitch-filter stability length in cycles (0..255); 0 means no filter.
REQ-004 SHALL have parameter RESET_CFG, default 0, CONF_WIDTH-bit value loaded into every cell slot at reset.
REQ-005 SHALL have ports, clock and reset first:
 clk  in  1  block clock, all logic on rising edge;
 rst_n  in  1  asynchronous active-low reset;
 reg_req  in  1  register access request, held until reg_ack;
 reg_we  in  1  1 = write, 0 = read;
 reg_addr  in  8  word address;
 reg_wdata  in  32  write data;
 reg_rdata  out  32  read data, valid with reg_ack;
 reg_ack  out  1  one-cycle access completion pulse;
 reg_err  out  1  error flag, valid with reg_ack;
 cell_cfg  out  NUM_CELLS*CONF_WIDTH  active config, cell n at bits [(n+1)*CONF_WIDTH-1 : n*CONF_WIDTH];
 pad_in  in  NUM_CELLS  raw asynchronous TO_CORE values from the cells;
 pad_in_filt  out  NUM_CELLS  synchronised, filtered pad inputs;
 cfg_update  out  1  one-cycle pulse when active config changes.

Function
REQ-006 SHALL hold, per cell, a shadow register and an active register, each CONF_WIDTH bits; cell_cfg SHALL be driven from the active registers only.
REQ-007 SHALL use this register map: 0..NUM_CELLS-1 = shadow of cell n (R/W, bits [CONF_WIDTH-1:0], upper bits write-ignored, read 0); NUM_CELLS = CTRL (bit0 COMMIT write-1, reads 0; bit1 FILT_EN R/W); NUM_CELLS+1 = STATUS (read-only, bit0 PENDING = any shadow differs from its active).
REQ-008 SHALL raise reg_ack exactly one cycle after the first cycle reg_req is sampled high, then deassert it for at least one cycle before acking the next request; a request held high after ack is a new request.
REQ-009 SHALL set reg_err with reg_ack for addresses >= NUM_CELLS+2 or any write to STATUS; errored writes change no state, errored reads return 0.
REQ-010 SHALL update the shadow register on the same clock edge that raises reg_ack for a shadow write.
REQ-011 SHALL, on a CTRL write with bit0 = 1, copy all shadows to all active registers on the edge that raises reg_ack; cfg_update SHALL be high in that same cycle only, and only if at least one active register changed.
REQ-012 SHALL NOT change any active register except via COMMIT; shadow writes without COMMIT SHALL leave cell_cfg unchanged.
REQ-013 SHALL pass each pad_in bit through a two-flop synchroniser; its output is s[n].
REQ-014 SHALL, when FILT_EN = 1 and FILT_LEN > 0, keep a per-cell counter: cleared when s[n] == pad_in_filt[n], else incremented; when the counter reaches FILT_LEN-1 with s[n] != pad_in_filt[n], pad_in_filt[n] SHALL take s[n] and the counter SHALL clear.
REQ-015 SHALL therefore change pad_in_filt[n] exactly 2+FILT_LEN cycles after a stable pad_in edge; pulses at s[n] shorter than FILT_LEN cycles SHALL be rejected and restart counting.
REQ-016 SHALL, when FILT_EN = 0 or FILT_LEN = 0, drive pad_in_filt[n] = s[n] registered (latency 3 cycles) and hold counters at 0.
REQ-017 SHALL size counters as clog2(FILT_LEN+1) bits; no wrap-around is permitted.
REQ-018 SHALL apply a FILT_EN change from the cycle after the CTRL write edge; in-progress counts SHALL be discarded.

Reset
REQ-019 SHALL, while rst_n is low, force: all shadows and actives = RESET_CFG, FILT_EN = 1, synchronisers, counters and pad_in_filt = 0, reg_ack = reg_err = cfg_update = 0, reg_rdata = 0.
REQ-020 SHALL abandon any in-flight access on reset assertion; no partial commit is permitted; the first access after release SHALL be acked normally.

Verification
REQ-021 Reset with RESET_CFG = 5'h03, NUM_CELLS = 25 -> cell_cfg = 25 copies of 5'h03, STATUS read = 0, CTRL read = 32'h2.
REQ-022 Write 5'h1A to cell 7, no commit -> cell_cfg unchanged, STATUS.PENDING = 1; write CTRL = 1 -> cell 7 slot = 5'h1A, cfg_update one cycle, PENDING = 0.
REQ-023 Commit with shadows equal to actives -> cell_cfg unchanged, cfg_update stays 0, reg_ack = 1, reg_err = 0.
REQ-024 Read address 27 and write address 26 (NUM_CELLS = 25) -> reg_ack with reg_err = 1, rdata = 0, STATUS unaffected.
REQ-025 FILT_LEN = 4: pad_in[3] high 3 cycles -> pad_in_filt[3] stays 0; high 10 cycles -> rises 6 cycles after the edge; FILT_EN = 0 -> follows after 3 cycles.
REQ-026 Assert rst_n low between reg_req and reg_ack of a shadow write plus commit -> all cells = RESET_CFG, no ack, no cfg_update.

Source files
------------

// File: rtl/io_cell_cfg_ctrl.sv
// IO cell configuration controller: per-cell shadow/active config registers with
// atomic commit over a req/ack register port, plus synchronised, glitch-filtered pad inputs.
module io_cell_cfg_ctrl #(
  parameter int                    NUM_CELLS  = 25,
  parameter int                    CONF_WIDTH = 5,
  parameter int                    FILT_LEN   = 4,
  parameter logic [CONF_WIDTH-1:0] RESET_CFG  = {CONF_WIDTH{1'b0}}
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            reg_req,
  input  logic                            reg_we,
  input  logic [7:0]                      reg_addr,
  input  logic [31:0]                     reg_wdata,
  output logic [31:0]                     reg_rdata,
  output logic                            reg_ack,
  output logic                            reg_err,
  output logic [NUM_CELLS*CONF_WIDTH-1:0] cell_cfg,
  input  logic [NUM_CELLS-1:0]            pad_in,
  output logic [NUM_CELLS-1:0]            pad_in_filt,
  output logic                            cfg_update
);

  localparam int               TOT_W        = NUM_CELLS * CONF_WIDTH;
  localparam logic [7:0]       ADDR_CTRL    = 8'(NUM_CELLS);
  localparam logic [7:0]       ADDR_STAT    = 8'(NUM_CELLS + 1);
  localparam bit               FILT_PRESENT = (FILT_LEN > 0);
  localparam int               CNT_W        = FILT_PRESENT ? $clog2(FILT_LEN + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(FILT_PRESENT ? FILT_LEN - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};

  logic [TOT_W-1:0]     r_shadow;
  logic [TOT_W-1:0]     r_active;
  logic                 r_filt_en;
  logic                 r_ack;
  logic                 r_err;
  logic                 r_cfg_update;
  logic [31:0]          r_rdata;
  logic [NUM_CELLS-1:0] r_sync1;
  logic [NUM_CELLS-1:0] r_sync2;
  logic [NUM_CELLS-1:0] r_filt;
  logic [CNT_W-1:0]     r_cnt [NUM_CELLS];

  logic        w_acc;
  logic        w_err;
  logic        w_wr_ok;
  logic        w_ctrl_wr;
  logic        w_pending;
  logic        w_filt_on;
  logic        w_filt_clr;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Access decode; an access is accepted only while no ack is outstanding
  always_comb begin
    w_acc      = reg_req & ~r_ack;
    w_err      = (reg_addr > ADDR_STAT) | (reg_we & (reg_addr == ADDR_STAT));
    w_wr_ok    = w_acc & reg_we & ~w_err;
    w_ctrl_wr  = w_wr_ok & (reg_addr == ADDR_CTRL);
    w_pending  = (r_shadow != r_active);
    w_filt_on  = r_filt_en & FILT_PRESENT;
    w_filt_clr = w_ctrl_wr & (reg_wdata[1] != r_filt_en);
    w_unused   = ^reg_wdata;
  end

  // Read data mux; errored accesses and writes return zero
  always_comb begin
    w_rdata = 32'h0000_0000;
    if (w_err || reg_we) begin
      w_rdata = 32'h0000_0000;
    end else if (reg_addr == ADDR_CTRL) begin
      w_rdata = {30'h0, r_filt_en, 1'b0};
    end else if (reg_addr == ADDR_STAT) begin
      w_rdata = {31'h0, w_pending};
    end else begin
      for (int n = 0; n < NUM_CELLS; n++) begin
        w_rdata[CONF_WIDTH-1:0] = w_rdata[CONF_WIDTH-1:0] |
          ((reg_addr == 8'(n)) ? r_shadow[n*CONF_WIDTH +: CONF_WIDTH] : {CONF_WIDTH{1'b0}});
      end
    end
  end

  // Register port, shadow/active config and commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow     <= {NUM_CELLS{RESET_CFG}};
      r_active     <= {NUM_CELLS{RESET_CFG}};
      r_filt_en    <= 1'b1;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
      r_cfg_update <= 1'b0;
      r_rdata      <= 32'h0000_0000;
    end else begin
      r_ack        <= w_acc;
      r_err        <= w_acc & w_err;
      r_rdata      <= w_acc ? w_rdata : 32'h0000_0000;
      r_cfg_update <= 1'b0;
      if (w_ctrl_wr) begin
        r_filt_en <= reg_wdata[1];
        if (reg_wdata[0]) begin
          r_active     <= r_shadow;
          r_cfg_update <= (r_shadow != r_active);
        end
      end else if (w_wr_ok) begin
        for (int n = 0; n < NUM_CELLS; n++) begin
          if (reg_addr == 8'(n)) begin
            r_shadow[n*CONF_WIDTH +: CONF_WIDTH] <= reg_wdata[CONF_WIDTH-1:0];
          end
        end
      end
    end
  end

  // Pad synchroniser and per-cell stability filter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= {NUM_CELLS{1'b0}};
      r_sync2 <= {NUM_CELLS{1'b0}};
      r_filt  <= {NUM_CELLS{1'b0}};
      for (int n = 0; n < NUM_CELLS; n++) begin
        r_cnt[n] <= CNT_ZERO;
      end
    end else begin
      r_sync1 <= pad_in;
      r_sync2 <= r_sync1;
      for (int n = 0; n < NUM_CELLS; n++) begin
        if (!w_filt_on) begin
          r_filt[n] <= r_sync2[n];
          r_cnt[n]  <= CNT_ZERO;
        end else if ((r_sync2[n] == r_filt[n]) || w_filt_clr) begin
          r_cnt[n] <= CNT_ZERO;
        end else if (r_cnt[n] == CNT_MAX) begin
          r_filt[n] <= r_sync2[n];
          r_cnt[n]  <= CNT_ZERO;
        end else begin
          r_cnt[n] <= r_cnt[n] + CNT_ONE;
        end
      end
    end
  end

  assign reg_ack     = r_ack;
  assign reg_err     = r_err;
  assign reg_rdata   = r_rdata;
  assign cfg_update  = r_cfg_update;
  assign cell_cfg    = r_active;
  assign pad_in_filt = r_filt;

endmodule
